// File: rtl/lvds_word_aligner.sv
// lvds_word_aligner: bitslips the LVDS receiver until TRAIN_PATTERN is seen MATCH_COUNT times in a row
//   clk, rst_n (sync, active-low), init_done, rx_dpa_locked, rx_data[DATA_W] in;
//   rx_data_align (bitslip pulse), aligned, align_fail, realign_req (pulse),
//   slip_count, err_count[16] out. All outputs registered.
//   Define LVDS_ALIGN_ERRCNT_EN to count mismatched words while aligned; otherwise err_count is 0.
module lvds_word_aligner #(
  parameter int                DATA_W        = 10,
  parameter logic [DATA_W-1:0] TRAIN_PATTERN = 10'b1111100000,
  parameter int                MATCH_COUNT   = 8,
  parameter int                SLIP_WAIT     = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        init_done,
  input  logic                        rx_dpa_locked,
  input  logic [DATA_W-1:0]           rx_data,
  output logic                        rx_data_align,
  output logic                        aligned,
  output logic                        align_fail,
  output logic                        realign_req,
  output logic [$clog2(DATA_W+1)-1:0] slip_count,
  output logic [15:0]                 err_count
);
  localparam int SW = $clog2(DATA_W+1);
  localparam int MW = $clog2(MATCH_COUNT+1);
  localparam int WW = $clog2(SLIP_WAIT+1);
  typedef enum logic [2:0] {IDLE, CHECK, SLIP, WAIT, LOCKED, FAIL} state_t;
  state_t state, nxt;
  logic [MW-1:0] match_cnt;
  logic [WW-1:0] wait_cnt;
  logic hit, last_slip, rq;
  assign hit = rx_data == TRAIN_PATTERN;
  assign last_slip = slip_count == SW'(DATA_W-1);
  always_comb begin
    nxt = state;
    rq = 1'b0;
    case (state)
      IDLE:   nxt = (init_done && rx_dpa_locked) ? CHECK : IDLE;
      CHECK: begin
        nxt = hit ? (match_cnt == MW'(MATCH_COUNT-1) ? LOCKED : CHECK) : (last_slip ? FAIL : SLIP);
        rq = !hit && last_slip;
      end
      SLIP:   nxt = WAIT;
      WAIT:   nxt = wait_cnt == WW'(SLIP_WAIT-1) ? CHECK : WAIT;
      LOCKED: begin
        nxt = rx_dpa_locked ? LOCKED : IDLE;
        rq = !rx_dpa_locked;
      end
      default: nxt = FAIL;
    endcase
    // losing init_done overrides everything and is not a realign request
    if (!init_done) begin
      nxt = IDLE;
      rq = 1'b0;
    end
  end
  // outputs are decoded from the next state so they line up with the state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      match_cnt <= '0;
      wait_cnt <= '0;
      slip_count <= '0;
      rx_data_align <= 1'b0;
      aligned <= 1'b0;
      align_fail <= 1'b0;
      realign_req <= 1'b0;
    end else begin
      state <= nxt;
      match_cnt <= (nxt == IDLE || state == SLIP) ? '0 : (state == CHECK && hit) ? match_cnt + 1'b1 : match_cnt;
      wait_cnt <= state == WAIT ? wait_cnt + 1'b1 : '0;
      slip_count <= nxt == IDLE ? '0 : state == SLIP ? slip_count + 1'b1 : slip_count;
      rx_data_align <= nxt == SLIP;
      aligned <= nxt == LOCKED;
      align_fail <= nxt == FAIL;
      realign_req <= rq;
    end
  end
`ifdef LVDS_ALIGN_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n || nxt == IDLE) err_count <= '0;
    else if (state == LOCKED && !hit && err_count != 16'hFFFF) err_count <= err_count + 1'b1;
  end
`else
  assign err_count = '0;
`endif
endmodule
